mipi_lane_merger: RTL and testbench

MIPI_LANE_MERGER -- requirements
Module: mipi_lane_merger

---
 rtl/mipi_pkg.sv | 16 +
 rtl/mipi_skew_fifo.sv | 66 ++++++
 rtl/mipi_lane_merger.sv | 155 +++++++++++++++
 tb/tb_mipi_lane_merger.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_pkg.sv
// Shared constants and types for the MIPI D-PHY lane merger.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: SYNC_BYTE (HS leader-sequence sync pattern) and state_t (merger FSM states).
package mipi_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HUNT     = 2'd1,
    STREAM   = 2'd2,
    WAIT_END = 2'd3
  } state_t;

endpackage

// File: rtl/mipi_skew_fifo.sv
// Per-lane skew buffer absorbing inter-lane sync offset.
// Latency: pushed byte is visible on dout the cycle after the push edge; dout is the live head.
// Backpressure: none; a push while full is accepted only if a pop happens in the same cycle.
// Ports: clk, rst (async, active-high), flush (sync clear), push/din, pop, dout, full, empty.
module mipi_skew_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mipi_lane_merger.sv
// Aligns LANES D-PHY byte streams on SYNC_BYTE and merges them into one word per cycle.
// Latency: byte sampled at edge k appears on out_data after edge k+2 (zero skew).
// Backpressure: none; overflow or skew timeout pulses err_skew and drops the burst.
// Ports: clk, rst (async, active-high), lane_data/lane_valid in; out_data/out_valid/out_sop,
//        burst_done, err_skew out (all registered).
module mipi_lane_merger
  import mipi_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int MAX_SKEW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*8-1:0] lane_data,
  input  logic [LANES-1:0]   lane_valid,
  output logic [LANES*8-1:0] out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               burst_done,
  output logic               err_skew
);

  localparam int DEPTH = MAX_SKEW + 1;
  localparam int CW    = $clog2(MAX_SKEW + 1);

  // Inputs are registered once; all decisions use the registered copy.
  logic [LANES*8-1:0] in_data_q;
  logic [LANES-1:0]   in_vld_q;
  state_t             state;
  logic [LANES-1:0]   synced;
  logic [CW-1:0]      skew_cnt;
  logic               sop_pend;

  logic [LANES-1:0]   new_sync;
  logic [LANES-1:0]   push;
  logic [LANES-1:0]   ovf;
  logic [LANES-1:0]   full;
  logic [LANES-1:0]   empty;
  logic [LANES*8-1:0] head;
  logic               live;
  logic               pop;
  logic               flush;
  logic               overflow;
  logic               all_synced_nxt;
  logic               hunt_timeout;
  logic               stream_end;

  assign live = (state != WAIT_END);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] byte_q;
    assign byte_q      = in_data_q[8*i +: 8];
    assign new_sync[i] = live && !synced[i] && in_vld_q[i] && (byte_q == SYNC_BYTE);
    // Overflow only when full and the head is not leaving this cycle.
    assign ovf[i]      = live && synced[i] && in_vld_q[i] && full[i] && !pop;
    assign push[i]     = live && synced[i] && in_vld_q[i] && !ovf[i];

    mipi_skew_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .din   (byte_q),
      .pop   (pop),
      .dout  (head[8*i +: 8]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign overflow       = |ovf;
  assign all_synced_nxt = &(synced | new_sync);
  assign pop            = (state == STREAM) && !(|empty);
  assign stream_end     = (state == STREAM) && !(|in_vld_q) && (|empty);
  // Counter would reach MAX_SKEW this edge while a lane is still missing.
  assign hunt_timeout   = (state == HUNT) && !all_synced_nxt && (skew_cnt == CW'(MAX_SKEW - 1));
  assign flush          = (state == WAIT_END) || stream_end || overflow || hunt_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data_q  <= '0;
      in_vld_q   <= '0;
      state      <= IDLE;
      synced     <= '0;
      skew_cnt   <= '0;
      sop_pend   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      burst_done <= 1'b0;
      err_skew   <= 1'b0;
    end else begin
      in_data_q  <= lane_data;
      in_vld_q   <= lane_valid;
      out_valid  <= pop;
      out_sop    <= pop && sop_pend;
      burst_done <= 1'b0;
      err_skew   <= 1'b0;
      if (pop) begin
        out_data <= head;
        sop_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          synced   <= new_sync;
          skew_cnt <= '0;
          if (all_synced_nxt) begin
            state    <= STREAM;
            sop_pend <= 1'b1;
          end else if (|new_sync) begin
            state <= HUNT;
          end
        end

        HUNT: begin
          synced   <= synced | new_sync;
          skew_cnt <= skew_cnt + 1'b1;
          if (overflow || hunt_timeout) begin
            err_skew <= 1'b1;
            synced   <= '0;
            state    <= WAIT_END;
          end else if (all_synced_nxt) begin
            state    <= STREAM;
            sop_pend <= 1'b1;
          end
        end

        STREAM: begin
          if (overflow) begin
            err_skew <= 1'b1;
            synced   <= '0;
            state    <= WAIT_END;
          end else if (stream_end) begin
            burst_done <= 1'b1;
            synced     <= '0;
            state      <= IDLE;
          end
        end

        WAIT_END: begin
          synced   <= '0;
          skew_cnt <= '0;
          if (!(|in_vld_q)) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_lane_merger.sv
// Directed bench for mipi_lane_merger: sync alignment, skew limits, leader, reset, ragged ends.
// Latency: n/a.
// Backpressure: n/a.
module tb_mipi_lane_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        burst_done;
  logic        err_skew;

  mipi_lane_merger #(
    .LANES    (4),
    .MAX_SKEW (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .burst_done (burst_done),
    .err_skew   (err_skew)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  logic [31:0] words[$];
  logic        sops[$];
  int          n_done, n_err, sop_bad;
  int          t_valid0, t_done0, t_first, t_drop;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        words.push_back(out_data);
        sops.push_back(out_sop);
        if (t_valid0 < 0) t_valid0 = cyc;
      end
      if (out_sop && !out_valid) sop_bad++;
      if (burst_done) begin
        n_done++;
        if (t_done0 < 0) t_done0 = cyc;
      end
      if (err_skew) n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    words.delete();
    sops.delete();
    n_done   = 0;
    n_err    = 0;
    t_valid0 = -1;
    t_done0  = -1;
    t_first  = -1;
    t_drop   = -1;
  endtask

  // Lane i starts at cycle off[i]: `lead` bytes of 00, then B8, then len[i]
  // data bytes where data byte j on lane i is 4*j+i.
  task automatic send(input int o0, input int o1, input int o2, input int o3,
                      input int l0, input int l1, input int l2, input int l3,
                      input int lead);
    int          off[4];
    int          len[4];
    int          last;
    int          p;
    logic [31:0] d;
    logic [3:0]  v;
    off  = '{o0, o1, o2, o3};
    len  = '{l0, l1, l2, l3};
    clear_mon();
    last = 0;
    for (int i = 0; i < 4; i++)
      if (off[i] + lead + len[i] + 1 > last) last = off[i] + lead + len[i] + 1;
    for (int c = 0; c < last; c++) begin
      d = '0;
      v = '0;
      for (int i = 0; i < 4; i++) begin
        p = c - off[i];
        if (p >= 0 && p < lead) begin
          v[i] = 1'b1;
          d[8*i +: 8] = 8'h00;
        end else if (p == lead) begin
          v[i] = 1'b1;
          d[8*i +: 8] = 8'hB8;
        end else if (p > lead && p <= lead + len[i]) begin
          v[i] = 1'b1;
          d[8*i +: 8] = 8'(4 * (p - lead - 1) + i);
        end
      end
      @(negedge clk);
      lane_data  = d;
      lane_valid = v;
      if (c == o0 + lead + 1) t_first = cyc + 1;
    end
    @(negedge clk);
    lane_data  = '0;
    lane_valid = '0;
    t_drop     = cyc + 1;
    repeat (8) @(negedge clk);
  endtask

  // Expected result of the reference 2-word burst: 03020100 (sop), 07060504.
  task automatic check_std(input string tag);
    check({tag, "_nwords"}, words.size(), 2);
    check({tag, "_w0"}, (words.size() > 0) ? words[0] : 32'hDEADBEEF, 32'h03020100);
    check({tag, "_w1"}, (words.size() > 1) ? words[1] : 32'hDEADBEEF, 32'h07060504);
    check({tag, "_sop0"}, (sops.size() > 0) ? 32'(sops[0]) : 32'hDEADBEEF, 32'd1);
    check({tag, "_sop1"}, (sops.size() > 1) ? 32'(sops[1]) : 32'hDEADBEEF, 32'd0);
    check({tag, "_done"}, n_done, 1);
    check({tag, "_err"}, n_err, 0);
  endtask

  initial begin
    logic found;
    clear_mon();
    sop_bad    = 0;
    rst        = 1'b1;
    lane_data  = 32'hB8B8B8B8;
    lane_valid = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {28'd0, out_valid, out_sop, burst_done, err_skew}, 32'd0);
    check("rst_data", out_data, 32'd0);
    lane_data  = '0;
    lane_valid = '0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);

    // Zero skew, with exact latency of data and burst_done.
    send(0, 0, 0, 0, 2, 2, 2, 2, 0);
    check_std("zero");
    check("zero_lat_data", t_valid0 - t_first, 2);
    check("zero_lat_done", t_done0 - t_drop, 2);
    check("hold_data", out_data, 32'h07060504);
    check("hold_valid", {31'd0, out_valid}, 32'd0);

    // Skew of exactly MAX_SKEW is tolerated.
    send(0, 0, 0, 3, 2, 2, 2, 2, 0);
    check_std("skew3");

    // Skew beyond MAX_SKEW: error, no data, then a clean burst recovers.
    send(0, 0, 0, 4, 2, 2, 2, 2, 0);
    check("skew4_err", n_err, 1);
    check("skew4_nwords", words.size(), 0);
    check("skew4_done", n_done, 0);
    send(0, 0, 0, 0, 2, 2, 2, 2, 0);
    check_std("after_skew4");

    // Leader bytes before sync are discarded.
    send(0, 0, 0, 0, 2, 2, 2, 2, 2);
    check_std("leader");

    // Reset in the middle of a stream.
    clear_mon();
    @(negedge clk);
    lane_data  = 32'hB8B8B8B8;
    lane_valid = 4'hF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      lane_data = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      lane_data = 32'h0F0E0D0C;
      if (out_valid) found = 1'b1;
    end
    check("mid_stream_seen", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", {28'd0, out_valid, out_sop, burst_done, err_skew}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    lane_data = 32'h11223344;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    lane_valid = '0;
    lane_data  = '0;
    repeat (2) @(negedge clk);
    send(0, 0, 0, 0, 2, 2, 2, 2, 0);
    check_std("after_rst");

    // Lane 2 carries one extra byte.
    send(0, 0, 0, 0, 2, 2, 3, 2, 0);
    check_std("ragged");

    check("sop_without_valid", sop_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
